crc16_gen_chk: RTL and testbench



---
 rtl/crc16_pkg.sv | 18 +
 rtl/crc16_byte_step.sv | 12 +
 rtl/crc16_gen_chk.sv | 97 +++++++++
 tb/tb_crc16_gen_chk.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc16_pkg.sv
// Shared constants and the byte-wide update for the reflected CRC-16/IBM
// (poly 0x8005 reflected as 0xA001, init 0xFFFF, no final XOR).
package crc16_pkg;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  // Fold one byte LSB-first into the running CRC.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational single-byte CRC-16 update; one instance per channel.
module crc16_byte_step
  import crc16_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_step(crc_i, byte_i);

endmodule

// File: rtl/crc16_gen_chk.sv
// CRC-16 generator (transmit) and checker (receive) for the UART link.
// Both channels share init/reset but otherwise run independently.
module crc16_gen_chk
  import crc16_pkg::*;
(
  input  logic        sclk,
  input  logic        reset,
  input  logic        init,
  input  logic [7:0]  Frame_data,
  input  logic        data_en,
  input  logic        CRC_rd,
  output logic [15:0] CRC_out,
  output logic        CRC_end,
  input  logic [7:0]  crc_din,
  input  logic        crc_en,
  input  logic        crc_chk_en,
  output logic        crc_err
);

  logic [15:0] gcrc_q, gcrc_d;
  logic [15:0] ccrc_q, ccrc_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic        crc_end_q, crc_end_d;
  logic        crc_err_q, crc_err_d;
  logic        rd_q;
  logic        rd_rise;
  logic [15:0] gcrc_step;
  logic [15:0] ccrc_step;

  crc16_byte_step u_gen_step (
    .crc_i  (gcrc_q),
    .byte_i (Frame_data),
    .crc_o  (gcrc_step)
  );

  crc16_byte_step u_chk_step (
    .crc_i  (ccrc_q),
    .byte_i (crc_din),
    .crc_o  (ccrc_step)
  );

  assign rd_rise = CRC_rd & ~rd_q;

  // Priority: init > read/check event > byte strobe; a byte colliding with
  // a higher-priority event is discarded.
  always_comb begin
    gcrc_d    = gcrc_q;
    crc_out_d = crc_out_q;
    crc_end_d = 1'b0;
    if (init) begin
      gcrc_d = CRC16_INIT;
    end else if (rd_rise) begin
      crc_out_d = gcrc_q;
      crc_end_d = 1'b1;
      gcrc_d    = CRC16_INIT;
    end else if (data_en) begin
      gcrc_d = gcrc_step;
    end
  end

  always_comb begin
    ccrc_d    = ccrc_q;
    crc_err_d = crc_err_q;
    if (init) begin
      ccrc_d    = CRC16_INIT;
      crc_err_d = 1'b0;
    end else if (crc_chk_en) begin
      crc_err_d = (ccrc_q != 16'h0000);
      ccrc_d    = CRC16_INIT;
    end else if (crc_en) begin
      ccrc_d = ccrc_step;
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      gcrc_q    <= CRC16_INIT;
      ccrc_q    <= CRC16_INIT;
      crc_out_q <= 16'h0000;
      crc_end_q <= 1'b0;
      crc_err_q <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      gcrc_q    <= gcrc_d;
      ccrc_q    <= ccrc_d;
      crc_out_q <= crc_out_d;
      crc_end_q <= crc_end_d;
      crc_err_q <= crc_err_d;
      rd_q      <= CRC_rd;
    end
  end

  assign CRC_out = crc_out_q;
  assign CRC_end = crc_end_q;
  assign crc_err = crc_err_q;

endmodule

// File: tb/tb_crc16_gen_chk.sv
// Scoreboard bench for crc16_gen_chk: drivers push expected CRC_out / crc_err
// values, monitors pop and compare when the DUT presents a result.
module tb_crc16_gen_chk;

  logic        sclk;
  logic        reset;
  logic        init;
  logic [7:0]  Frame_data;
  logic        data_en;
  logic        CRC_rd;
  logic [15:0] CRC_out;
  logic        CRC_end;
  logic [7:0]  crc_din;
  logic        crc_en;
  logic        crc_chk_en;
  logic        crc_err;

  crc16_gen_chk dut (
    .sclk       (sclk),
    .reset      (reset),
    .init       (init),
    .Frame_data (Frame_data),
    .data_en    (data_en),
    .CRC_rd     (CRC_rd),
    .CRC_out    (CRC_out),
    .CRC_end    (CRC_end),
    .crc_din    (crc_din),
    .crc_en     (crc_en),
    .crc_chk_en (crc_chk_en),
    .crc_err    (crc_err)
  );

  // ---------------- clock / reset ----------------
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] gen_q[$];
  logic [0:0]  err_q[$];
  logic [7:0]  frame[$];
  logic        chk_pending = 1'b0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Bit-serial reference: feedback bit is crc[0] xor the incoming data bit.
  function automatic logic [15:0] ref_crc(input logic [7:0] bytes[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ bytes[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  // ---------------- monitors ----------------
  always @(posedge sclk) chk_pending <= crc_chk_en && !reset && !init;

  always @(negedge sclk) begin
    if (CRC_end) begin
      if (gen_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL crc_end_unexpected actual=1 expected=0 out=%h", CRC_out);
      end else begin
        cmp("crc_out", CRC_out, gen_q.pop_front());
      end
    end
    if (chk_pending) begin
      if (err_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL crc_err_unexpected_check actual=%b expected=none", crc_err);
      end else begin
        cmp("crc_err", {15'h0, crc_err}, {15'h0, err_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic gen_byte(input logic [7:0] b);
    Frame_data = b;
    data_en    = 1'b1;
    tick();
    data_en    = 1'b0;
  endtask

  task automatic chk_byte(input logic [7:0] b);
    crc_din = b;
    crc_en  = 1'b1;
    tick();
    crc_en  = 1'b0;
  endtask

  task automatic gen_frame();
    foreach (frame[k]) gen_byte(frame[k]);
  endtask

  task automatic chk_frame();
    foreach (frame[k]) chk_byte(frame[k]);
  endtask

  task automatic gen_read(input logic [15:0] exp);
    gen_q.push_back(exp);
    CRC_rd = 1'b1;
    tick();
    tick();
    CRC_rd = 1'b0;
    tick();
  endtask

  task automatic do_check(input logic exp);
    err_q.push_back(exp);
    crc_chk_en = 1'b1;
    tick();
    crc_chk_en = 1'b0;
    tick();
  endtask

  task automatic load_ref_frame();
    frame = '{8'h80, 8'h00, 8'h02, 8'h0F, 8'h0B};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] exp;
    int          len;

    reset = 1'b1; init = 1'b0; Frame_data = 8'h00; data_en = 1'b0;
    CRC_rd = 1'b0; crc_din = 8'h00; crc_en = 1'b0; crc_chk_en = 1'b0;
    repeat (3) tick();
    cmp("reset_crc_out", CRC_out, 16'h0000);
    cmp("reset_crc_end", {15'h0, CRC_end}, 16'h0);
    cmp("reset_crc_err", {15'h0, crc_err}, 16'h0);
    reset = 1'b0;
    tick();

    // Reference generator vector
    do_init();
    load_ref_frame();
    gen_frame();
    gen_read(16'h29C0);

    // Empty frame, then a fresh-seeded frame after the read
    do_init();
    gen_read(16'hFFFF);
    gen_frame();
    gen_read(16'h29C0);

    // Standard check string and a single zero byte
    frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    gen_frame();
    gen_read(16'h4B37);
    frame = '{8'h00};
    gen_frame();
    gen_read(16'h40BF);

    // Byte in the CRC_rd rising cycle is dropped; bytes while held high start the next frame
    load_ref_frame();
    gen_frame();
    gen_q.push_back(16'h29C0);
    CRC_rd = 1'b1; Frame_data = 8'h55; data_en = 1'b1;
    tick();
    data_en = 1'b0;
    gen_frame();
    CRC_rd = 1'b0;
    tick();
    gen_read(16'h29C0);

    // init mid-frame and init colliding with a byte
    gen_byte(8'h12);
    gen_byte(8'h34);
    do_init();
    Frame_data = 8'h77; data_en = 1'b1; init = 1'b1;
    tick();
    data_en = 1'b0; init = 1'b0;
    gen_frame();
    gen_read(16'h29C0);

    // Checker: pass, wrong CRC byte, hold, flipped data bit, recovery
    frame = '{8'h80, 8'h00, 8'h02, 8'h0F, 8'h0B, 8'hC0, 8'h29};
    chk_frame();
    do_check(1'b0);
    frame = '{8'h80, 8'h00, 8'h02, 8'h0F, 8'h0B, 8'hC0, 8'h28};
    chk_frame();
    do_check(1'b1);
    repeat (3) tick();
    cmp("crc_err_hold", {15'h0, crc_err}, 16'h0001);
    frame = '{8'h80, 8'h01, 8'h02, 8'h0F, 8'h0B, 8'hC0, 8'h29};
    chk_frame();
    do_check(1'b1);
    frame = '{8'h80, 8'h00, 8'h02, 8'h0F, 8'h0B, 8'hC0, 8'h29};
    chk_frame();
    do_check(1'b0);

    // Empty checker frame leaves residue 0xFFFF -> error
    do_check(1'b1);

    // Check strobe together with a byte: byte dropped, check uses prior residue
    frame = '{8'h80, 8'h00, 8'h02, 8'h0F, 8'h0B, 8'hC0, 8'h29};
    chk_frame();
    err_q.push_back(1'b0);
    crc_din = 8'h5A; crc_en = 1'b1; crc_chk_en = 1'b1;
    tick();
    crc_en = 1'b0; crc_chk_en = 1'b0;
    frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h37, 8'h4B};
    chk_frame();
    do_check(1'b0);

    // Reset mid-frame with a failing result and nonzero CRC_out held
    frame = '{8'h01, 8'h02};
    chk_frame();
    do_check(1'b1);
    gen_byte(8'h12);
    gen_byte(8'h34);
    reset = 1'b1;
    tick();
    cmp("midreset_crc_out", CRC_out, 16'h0000);
    cmp("midreset_crc_end", {15'h0, CRC_end}, 16'h0);
    cmp("midreset_crc_err", {15'h0, crc_err}, 16'h0);
    reset = 1'b0;
    tick();
    load_ref_frame();
    gen_frame();
    gen_read(16'h29C0);

    // Random frames: generator vs reference, checker residue always zero
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 64);
      frame.delete();
      for (int k = 0; k < len; k++) frame.push_back(8'($urandom_range(0, 255)));
      exp = ref_crc(frame);
      gen_frame();
      gen_read(exp);
      frame.push_back(exp[7:0]);
      frame.push_back(exp[15:8]);
      chk_frame();
      do_check(1'b0);
    end

    repeat (3) tick();
    cmp("gen_queue_drained", 16'(gen_q.size()), 16'h0);
    cmp("err_queue_drained", 16'(err_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends with a summary line
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
